// File: rtl/ex_modmul_stage.sv
// Execute stage of the RSA ASIP: single-cycle add or multi-cycle interleaved
// modular multiply (A*B mod M), with results registered toward MEM.
module ex_modmul_stage #(
    parameter int unsigned N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid_ex,
    input  logic [N-1:0] rda_ex,
    input  logic [N-1:0] rdb_ex,
    input  logic [N-1:0] extended_ex,
    input  logic         opb_selector_ex,
    input  logic         alu_func_ex,
    input  logic [4:0]   rw_ex,
    input  logic         wr_en_ex,
    input  logic         wd_selector_ex,
    input  logic         wm_ex,
    input  logic [N-1:0] mod_m,
    output logic         stall,
    output logic         busy,
    output logic [N-1:0] alu_result_mem,
    output logic [N-1:0] wd_mem,
    output logic [4:0]   rw_mem,
    output logic         wr_en_mem,
    output logic         wd_selector_mem,
    output logic         wm_mem
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t         state_q, state_d;
    logic [N+1:0]   p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           load_op;
    logic           stall_c;

    logic [N-1:0]   a_q, b_q, m_q, sd_q;
    logic [4:0]     rw_q;
    logic           wr_en_q, wd_sel_q, wm_q;

    logic [N-1:0]   res_q, res_d, wd_q, wd_d;
    logic [4:0]     rwm_q, rwm_d;
    logic           wrm_q, wrm_d, wdsm_q, wdsm_d, wmm_q, wmm_d;

    logic [N-1:0]   opb;
    logic [N+1:0]   m_ext, t0, t1, t2;

    assign opb   = opb_selector_ex ? extended_ex : rdb_ex;
    assign m_ext = {2'b00, m_q};

    // With P,A < M, 2P+A < 3M, so two conditional subtractions restore P < M.
    assign t0 = {p_q[N:0], 1'b0} + (b_q[cnt_q] ? {2'b00, a_q} : '0);
    assign t1 = (t0 >= m_ext) ? t0 - m_ext : t0;
    assign t2 = (t1 >= m_ext) ? t1 - m_ext : t1;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        load_op = 1'b0;
        stall_c = 1'b0;
        busy    = 1'b0;
        res_d   = '0;
        wd_d    = '0;
        rwm_d   = '0;
        wrm_d   = 1'b0;
        wdsm_d  = 1'b0;
        wmm_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_ex && alu_func_ex) begin
                    stall_c = 1'b1;
                    load_op = 1'b1;
                    p_d     = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = MUL;
                end else if (valid_ex) begin
                    res_d  = rda_ex + opb;
                    wd_d   = rdb_ex;
                    rwm_d  = rw_ex;
                    wrm_d  = wr_en_ex;
                    wdsm_d = wd_selector_ex;
                    wmm_d  = wm_ex;
                end
            end
            MUL: begin
                stall_c = 1'b1;
                busy    = 1'b1;
                p_d     = t2;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                res_d   = (m_q == '0) ? '0 : p_q[N-1:0];
                wd_d    = sd_q;
                rwm_d   = rw_q;
                wrm_d   = wr_en_q;
                wdsm_d  = wd_sel_q;
                wmm_d   = wm_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the issue path so stall drops even while an issue is presented.
    assign stall = reset & stall_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            wd_q    <= '0;
            rwm_q   <= '0;
            wrm_q   <= 1'b0;
            wdsm_q  <= 1'b0;
            wmm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wd_q    <= wd_d;
            rwm_q   <= rwm_d;
            wrm_q   <= wrm_d;
            wdsm_q  <= wdsm_d;
            wmm_q   <= wmm_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            sd_q     <= '0;
            rw_q     <= '0;
            wr_en_q  <= 1'b0;
            wd_sel_q <= 1'b0;
            wm_q     <= 1'b0;
        end else if (load_op) begin
            a_q      <= rda_ex;
            b_q      <= opb;
            m_q      <= mod_m;
            sd_q     <= rdb_ex;
            rw_q     <= rw_ex;
            wr_en_q  <= wr_en_ex;
            wd_sel_q <= wd_selector_ex;
            wm_q     <= wm_ex;
        end
    end

    assign alu_result_mem  = res_q;
    assign wd_mem          = wd_q;
    assign rw_mem          = rwm_q;
    assign wr_en_mem       = wrm_q;
    assign wd_selector_mem = wdsm_q;
    assign wm_mem          = wmm_q;

endmodule

// File: tb/tb_ex_modmul_stage.sv
// Directed bench for ex_modmul_stage: vector table for single-cycle ops,
// hand-written sequences for multiply timing, back-to-back issue and reset.
module tb_ex_modmul_stage;

    localparam int unsigned N = 32;

    logic         clock;
    logic         reset;
    logic         valid_ex;
    logic [N-1:0] rda_ex, rdb_ex, extended_ex, mod_m;
    logic         opb_selector_ex, alu_func_ex;
    logic [4:0]   rw_ex;
    logic         wr_en_ex, wd_selector_ex, wm_ex;
    logic         stall, busy;
    logic [N-1:0] alu_result_mem, wd_mem;
    logic [4:0]   rw_mem;
    logic         wr_en_mem, wd_selector_mem, wm_mem;

    int checks = 0;
    int errors = 0;

    ex_modmul_stage #(.N(N)) dut (
        .clock(clock), .reset(reset), .valid_ex(valid_ex),
        .rda_ex(rda_ex), .rdb_ex(rdb_ex), .extended_ex(extended_ex),
        .opb_selector_ex(opb_selector_ex), .alu_func_ex(alu_func_ex),
        .rw_ex(rw_ex), .wr_en_ex(wr_en_ex), .wd_selector_ex(wd_selector_ex),
        .wm_ex(wm_ex), .mod_m(mod_m), .stall(stall), .busy(busy),
        .alu_result_mem(alu_result_mem), .wd_mem(wd_mem), .rw_mem(rw_mem),
        .wr_en_mem(wr_en_mem), .wd_selector_mem(wd_selector_mem), .wm_mem(wm_mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        valid, func, sel;
        logic [31:0] rda, rdb, ext;
        logic [4:0]  rw;
        logic        wr_en, wd_sel, wm;
        logic [31:0] e_res, e_wd;
        logic [4:0]  e_rw;
        logic        e_wr, e_wds, e_wm;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_mem_zero(input string tag);
        check({tag, "_res"}, alu_result_mem, 32'h0);
        check({tag, "_wd"}, wd_mem, 32'h0);
        check({tag, "_rw"}, {27'h0, rw_mem}, 32'h0);
        check({tag, "_ctl"}, {29'h0, wr_en_mem, wd_selector_mem, wm_mem}, 32'h0);
    endtask

    task automatic bubble_in();
        valid_ex = 1'b0; alu_func_ex = 1'b0; opb_selector_ex = 1'b0;
        rda_ex = '0; rdb_ex = '0; extended_ex = '0; rw_ex = '0;
        wr_en_ex = 1'b0; wd_selector_ex = 1'b0; wm_ex = 1'b0;
    endtask

    // Entered at least 2 time units before a rising edge; that cycle is c0.
    // Returns 2 time units into c(N+2), after the result has been checked.
    task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] m, input logic [31:0] exp, input logic [4:0] rw);
        valid_ex = 1'b1; alu_func_ex = 1'b1; opb_selector_ex = 1'b0;
        rda_ex = a; rdb_ex = b; extended_ex = 32'hDEAD_BEEF; mod_m = m;
        rw_ex = rw; wr_en_ex = 1'b1; wd_selector_ex = 1'b1; wm_ex = 1'b0;
        #1;
        check({name, "_stall_c0"}, {31'h0, stall}, 32'h1);
        check({name, "_busy_c0"}, {31'h0, busy}, 32'h0);
        for (int c = 1; c <= N + 1; c++) begin
            @(posedge clock); #1;
            rda_ex = ~a; rdb_ex = ~b; rw_ex = ~rw; opb_selector_ex = 1'b1;
            mod_m = (c % 2 == 1) ? (m ^ 32'h0000_0F0F) : (m + 32'd3);
            #1;
            check($sformatf("%s_stall_c%0d", name, c), {31'h0, stall}, {31'h0, (c <= N)});
            check($sformatf("%s_wren_c%0d", name, c), {31'h0, wr_en_mem}, 32'h0);
            if (c == 1 || c == N + 1) begin
                check($sformatf("%s_busy_c%0d", name, c), {31'h0, busy}, 32'h1);
                check($sformatf("%s_res_c%0d", name, c), alu_result_mem, 32'h0);
            end
        end
        @(posedge clock); #1;
        bubble_in();
        #1;
        check({name, "_result"}, alu_result_mem, exp);
        check({name, "_wd"}, wd_mem, b);
        check({name, "_rw"}, {27'h0, rw_mem}, {27'h0, rw});
        check({name, "_ctl"}, {29'h0, wr_en_mem, wd_selector_mem, wm_mem}, 32'h6);
        check({name, "_stall_end"}, {31'h0, stall}, 32'h0);
        check({name, "_busy_end"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        //            v  f  s  rda           rdb           ext           rw  we ws wm  e_res         e_wd          e_rw we ws wm
        vecs[0] = '{1, 0, 1, 32'd3,        32'hAAAA0000, 32'hFFFFFFFF, 5,  1, 0, 0, 32'd2,        32'hAAAA0000, 5,  1, 0, 0};
        vecs[1] = '{1, 0, 0, 32'h80000000, 32'h80000000, 32'h0,        31, 1, 1, 1, 32'h0,        32'h80000000, 31, 1, 1, 1};
        vecs[2] = '{1, 0, 0, 32'h12345678, 32'h11111111, 32'h0,        0,  0, 0, 1, 32'h23456789, 32'h11111111, 0,  0, 0, 1};
        vecs[3] = '{0, 1, 1, 32'd5,        32'd7,        32'd9,        4,  1, 1, 1, 32'h0,        32'h0,        0,  0, 0, 0};
        vecs[4] = '{0, 0, 0, 32'd8,        32'd9,        32'd1,        9,  1, 0, 0, 32'h0,        32'h0,        0,  0, 0, 0};
        vecs[5] = '{1, 0, 1, 32'hFFFFFFFF, 32'h00000055, 32'h1,        17, 1, 0, 0, 32'h0,        32'h00000055, 17, 1, 0, 0};

        reset = 1'b0;
        mod_m = '0;
        bubble_in();
        repeat (2) @(posedge clock);
        #2;
        check_mem_zero("reset");
        check("reset_busy", {31'h0, busy}, 32'h0);
        valid_ex = 1'b1; alu_func_ex = 1'b1;
        #1;
        check("reset_stall_gated", {31'h0, stall}, 32'h0);
        bubble_in();
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            valid_ex = vecs[i].valid; alu_func_ex = vecs[i].func; opb_selector_ex = vecs[i].sel;
            rda_ex = vecs[i].rda; rdb_ex = vecs[i].rdb; extended_ex = vecs[i].ext;
            rw_ex = vecs[i].rw; wr_en_ex = vecs[i].wr_en;
            wd_selector_ex = vecs[i].wd_sel; wm_ex = vecs[i].wm;
            #1;
            check($sformatf("v%0d_stall", i), {31'h0, stall}, 32'h0);
            @(posedge clock); #2;
            check($sformatf("v%0d_res", i), alu_result_mem, vecs[i].e_res);
            check($sformatf("v%0d_wd", i), wd_mem, vecs[i].e_wd);
            check($sformatf("v%0d_rw", i), {27'h0, rw_mem}, {27'h0, vecs[i].e_rw});
            check($sformatf("v%0d_ctl", i), {29'h0, wr_en_mem, wd_selector_mem, wm_mem},
                  {29'h0, vecs[i].e_wr, vecs[i].e_wds, vecs[i].e_wm});
            check($sformatf("v%0d_busy", i), {31'h0, busy}, 32'h0);
        end
        bubble_in();
        @(posedge clock); #2;

        do_mul("mul_small", 32'd5, 32'd7, 32'd11, 32'd2, 5'd3);
        do_mul("mul_mid", 32'h1234, 32'h5678, 32'hFFFB, 32'h00001F1E, 5'd8);
        do_mul("mul_wide", 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 5'd12);
        do_mul("b2b_first", 32'd5, 32'd7, 32'd11, 32'd2, 5'd1);
        do_mul("b2b_second", 32'd3, 32'd4, 32'd7, 32'd5, 5'd2);
        do_mul("mul_m0", 32'd5, 32'd7, 32'd0, 32'd0, 5'd6);

        // Async reset clears registered MEM outputs holding a real result.
        valid_ex = 1'b1; alu_func_ex = 1'b0; opb_selector_ex = 1'b0;
        rda_ex = 32'd1; rdb_ex = 32'd1; rw_ex = 5'd3; wr_en_ex = 1'b1;
        @(posedge clock); #2;
        check("pre_reset_add", alu_result_mem, 32'd2);
        reset = 1'b0;
        #1;
        check_mem_zero("async_reset");
        bubble_in();
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #2;

        // Multiply issued in c0, reset dropped in c16 (cnt==16).
        valid_ex = 1'b1; alu_func_ex = 1'b1;
        rda_ex = 32'd5; rdb_ex = 32'd7; mod_m = 32'd11; rw_ex = 5'd4; wr_en_ex = 1'b1;
        repeat (16) @(posedge clock);
        #2;
        check("midmul_stall", {31'h0, stall}, 32'h1);
        check("midmul_busy", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        check("rst_midmul_stall", {31'h0, stall}, 32'h0);
        check("rst_midmul_busy", {31'h0, busy}, 32'h0);
        check_mem_zero("rst_midmul");
        valid_ex = 1'b1; alu_func_ex = 1'b0; opb_selector_ex = 1'b0;
        rda_ex = 32'd10; rdb_ex = 32'd20; rw_ex = 5'd7; wr_en_ex = 1'b1;
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        check("post_reset_stall", {31'h0, stall}, 32'h0);
        @(posedge clock); #2;
        check("post_reset_add", alu_result_mem, 32'd30);
        check("post_reset_rw", {27'h0, rw_mem}, 32'd7);
        check("post_reset_wren", {31'h0, wr_en_mem}, 32'h1);
        bubble_in();
        @(posedge clock); #2;
        check("post_reset_bubble", {31'h0, wr_en_mem}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
